// File: rtl/frequency_meter_if.sv
// Measurement bus of the frequency meter: enable and signal in, BCD result and status out.
interface frequency_meter_if #(
  parameter int DIGITS = 6
);
  logic                  EN;
  logic                  SIG_IN;
  logic [4*DIGITS-1:0]   FREQ_BCD;
  logic                  VALID;
  logic                  OVF;
  logic                  BUSY;

  modport master (output EN, SIG_IN, input FREQ_BCD, VALID, OVF, BUSY);
  modport slave  (input EN, SIG_IN, output FREQ_BCD, VALID, OVF, BUSY);
endinterface

// File: rtl/frequency_meter.sv
// Gated frequency meter: counts synchronized SIG_IN rising edges over a fixed CP window
// in a saturating BCD counter and latches the result once per window.
module frequency_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int DIGITS      = 6
) (
  input  logic              CP,
  input  logic              nCR,
  frequency_meter_if.slave  bus
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LATCH} state_t;

  state_t                   state_reg;
  logic                     sync1_reg;
  logic                     sync2_reg;
  logic                     hist_reg;
  logic [GW-1:0]            gate_reg;
  logic [DIGITS-1:0][3:0]   count_reg;
  logic                     ovf_flag_reg;
  logic [4*DIGITS-1:0]      freq_reg;
  logic                     valid_reg;
  logic                     ovf_reg;
  logic                     busy_reg;

  logic                     edge_det;
  logic [DIGITS-1:0]        carry;
  logic [DIGITS-1:0]        digit_nine;
  logic [DIGITS-1:0][3:0]   count_inc;
  logic                     all_nine;

  assign edge_det = sync2_reg & ~hist_reg;

  // count_inc is the counter value plus one, with the carry rippling through all digits
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign digit_nine[gi] = (count_reg[gi] == 4'd9);
    assign count_inc[gi]  = !carry[gi]     ? count_reg[gi] :
                            digit_nine[gi] ? 4'd0          : count_reg[gi] + 4'd1;
    if (gi < DIGITS - 1) begin : g_carry
      assign carry[gi+1] = carry[gi] & digit_nine[gi];
    end
  end

  assign all_nine = &digit_nine;

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_reg    <= IDLE;
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      hist_reg     <= 1'b0;
      gate_reg     <= '0;
      count_reg    <= '0;
      ovf_flag_reg <= 1'b0;
      freq_reg     <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      sync1_reg <= bus.SIG_IN;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          gate_reg     <= '0;
          count_reg    <= '0;
          ovf_flag_reg <= 1'b0;
          if (bus.EN) begin
            state_reg <= MEASURE;
            busy_reg  <= 1'b1;
          end
        end
        MEASURE: begin
          if (!bus.EN) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            gate_reg     <= '0;
            count_reg    <= '0;
            ovf_flag_reg <= 1'b0;
          end else begin
            // A saturated counter stays at all nines; only the flag records the excess
            if (edge_det) begin
              if (all_nine) ovf_flag_reg <= 1'b1;
              else          count_reg    <= count_inc;
            end
            if (gate_reg == GATE_LAST) begin
              gate_reg  <= '0;
              state_reg <= LATCH;
            end else begin
              gate_reg <= gate_reg + GW'(1);
            end
          end
        end
        LATCH: begin
          freq_reg     <= count_reg;
          ovf_reg      <= ovf_flag_reg;
          valid_reg    <= 1'b1;
          gate_reg     <= '0;
          count_reg    <= '0;
          ovf_flag_reg <= 1'b0;
          if (bus.EN) begin
            state_reg <= MEASURE;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.FREQ_BCD = freq_reg;
  assign bus.VALID    = valid_reg;
  assign bus.OVF      = ovf_reg;
  assign bus.BUSY     = busy_reg;

endmodule

// File: tb/tb_frequency_meter.sv
// Bench for frequency_meter: three instances (100/6, 200/6, 300/2) checked every cycle
// against an integer-count window model, plus hand-computed window results and timings.
module tb_frequency_meter;

  localparam int GATE_T [3] = '{100, 200, 300};
  localparam int DIG_T  [3] = '{6, 6, 2};

  logic        clk = 1'b0;
  logic        ncr = 1'b0;
  logic [2:0]  en_drv = '0;
  logic [2:0]  sig_drv = '0;
  logic [23:0] freq_obs [3];
  logic [2:0]  valid_obs;
  logic [2:0]  ovf_obs;
  logic [2:0]  busy_obs;

  int          pcyc = 0;
  int          sig_per [3] = '{10, 2, 2};
  logic [2:0]  sig_lvl = '0;
  int          checks = 0;
  int          errors = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    frequency_meter_if #(.DIGITS(DIG_T[gi])) bus ();
    assign bus.EN        = en_drv[gi];
    assign bus.SIG_IN    = sig_drv[gi];
    assign freq_obs[gi]  = 24'(bus.FREQ_BCD);
    assign valid_obs[gi] = bus.VALID;
    assign ovf_obs[gi]   = bus.OVF;
    assign busy_obs[gi]  = bus.BUSY;
    frequency_meter #(.GATE_CYCLES(GATE_T[gi]), .DIGITS(DIG_T[gi])) dut (
      .CP  (clk),
      .nCR (ncr),
      .bus (bus)
    );
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp_v);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v, input int d);
    logic [23:0] r = '0;
    int x = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int max_count(input int d);
    int m = 1;
    for (int k = 0; k < d; k++) m = m * 10;
    return m - 1;
  endfunction

  // Signal sampled at the posedge after cycle P is high for the first half of each period
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (sig_per[i] == 0) sig_drv[i] = sig_lvl[i];
        else sig_drv[i] = ((pcyc % sig_per[i]) < (sig_per[i] / 2)) ? 1'b1 : 1'b0;
      end
    end
  end

  // Model: phase -1 idle, 0..G-1 gate position, G latch; edges kept as a plain integer
  int          m_phase [3] = '{-1, -1, -1};
  int          m_cnt   [3] = '{0, 0, 0};
  logic [2:0]  m_hist  [3] = '{3'b0, 3'b0, 3'b0};
  logic [23:0] m_freq  [3] = '{24'h0, 24'h0, 24'h0};
  logic [2:0]  m_ovf = '0;
  logic [2:0]  m_valid = '0;

  initial begin
    logic rise;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!ncr) begin
          m_phase[i] = -1; m_cnt[i] = 0; m_hist[i] = '0;
          m_freq[i] = '0; m_ovf[i] = 1'b0; m_valid[i] = 1'b0;
        end else begin
          // a rising edge sampled two posedges ago reaches the counter now
          rise = m_hist[i][1] & ~m_hist[i][2];
          m_hist[i] = {m_hist[i][1:0], sig_drv[i]};
          m_valid[i] = 1'b0;
          if (m_phase[i] < 0) begin
            m_cnt[i] = 0;
            if (en_drv[i]) m_phase[i] = 0;
          end else if (m_phase[i] < GATE_T[i]) begin
            if (!en_drv[i]) begin
              m_phase[i] = -1; m_cnt[i] = 0;
            end else begin
              if (rise) m_cnt[i] = m_cnt[i] + 1;
              m_phase[i] = m_phase[i] + 1;
            end
          end else begin
            m_valid[i] = 1'b1;
            m_ovf[i]   = (m_cnt[i] > max_count(DIG_T[i]));
            m_freq[i]  = to_bcd(m_ovf[i] ? max_count(DIG_T[i]) : m_cnt[i], DIG_T[i]);
            m_cnt[i]   = 0;
            m_phase[i] = en_drv[i] ? 0 : -1;
          end
        end
        check("valid", i, 32'(valid_obs[i]), 32'(m_valid[i]));
        check("busy",  i, 32'(busy_obs[i]),  32'(m_phase[i] >= 0));
        check("freq",  i, 32'(freq_obs[i]),  32'(m_freq[i]));
        check("ovf",   i, 32'(ovf_obs[i]),   32'(m_ovf[i]));
      end
    end
  end

  task automatic wait_valid(input int i, input int budget, output int at);
    at = -1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (valid_obs[i]) begin
        at = pcyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout[%0d] got no VALID want one within %0d cycles", i, budget);
    end else begin
      $display("inst %0d VALID at cycle %0d FREQ_BCD=%0h OVF=%b", i, at, freq_obs[i], ovf_obs[i]);
    end
  endtask

  initial begin
    int r, a0, a1, b, v, e, nv;
    repeat (3) @(negedge clk);
    check("rst_freq", 0, 32'(freq_obs[0]), 0);
    check("rst_valid", 0, 32'(valid_obs[0]), 0);
    check("rst_ovf", 0, 32'(ovf_obs[0]), 0);
    check("rst_busy", 0, 32'(busy_obs[0]), 0);

    // release aligned so every first window sees exactly the steady-state edge count
    en_drv = 3'b111;
    do @(negedge clk); while (pcyc % 10 != 0);
    ncr = 1'b1;
    r = pcyc + 1;

    wait_valid(0, 200, a0);
    check("first_valid_cycle", 0, a0, r + 101);
    check("win_freq", 0, 32'(freq_obs[0]), 32'h000010);
    check("win_ovf", 0, 32'(ovf_obs[0]), 0);
    wait_valid(1, 200, b);
    check("first_valid_cycle", 1, b, r + 201);
    check("ripple_freq", 1, 32'(freq_obs[1]), 32'h000100);
    wait_valid(0, 200, a1);
    check("valid_spacing", 0, a1 - a0, 101);

    while (pcyc < r + 290) begin @(posedge clk); #1; end
    @(negedge clk);
    sig_per[2] = 0; sig_lvl[2] = 1'b0;
    wait_valid(2, 100, b);
    check("sat_freq", 2, 32'(freq_obs[2]), 32'h99);
    check("sat_ovf", 2, 32'(ovf_obs[2]), 1);
    wait_valid(2, 400, b);
    check("quiet_freq", 2, 32'(freq_obs[2]), 32'h00);
    check("quiet_ovf", 2, 32'(ovf_obs[2]), 0);

    @(negedge clk);
    sig_per[0] = 0; sig_lvl[0] = 1'b1;
    wait_valid(0, 200, a0);
    wait_valid(0, 200, a0);
    check("const_high_freq", 0, 32'(freq_obs[0]), 0);

    @(negedge clk);
    sig_per[0] = 10;
    wait_valid(0, 200, a0);
    wait_valid(0, 200, v);
    check("restored_freq", 0, 32'(freq_obs[0]), 32'h000010);

    while (pcyc < v + 50) begin @(posedge clk); #1; end
    @(negedge clk);
    en_drv[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 0, 32'(busy_obs[0]), 0);
    check("abort_valid", 0, 32'(valid_obs[0]), 0);
    check("abort_freq_hold", 0, 32'(freq_obs[0]), 32'h000010);
    nv = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (valid_obs[0]) nv++;
    end
    check("abort_no_valid", 0, nv, 0);
    @(negedge clk);
    en_drv[0] = 1'b1;
    e = pcyc + 1;
    wait_valid(0, 200, a0);
    check("fresh_valid_cycle", 0, a0, e + 101);
    check("fresh_freq", 0, 32'(freq_obs[0]), 32'h000010);

    repeat (40) @(posedge clk);
    @(negedge clk); #2;
    ncr = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("async_freq", i, 32'(freq_obs[i]), 0);
      check("async_valid", i, 32'(valid_obs[i]), 0);
      check("async_ovf", i, 32'(ovf_obs[i]), 0);
      check("async_busy", i, 32'(busy_obs[i]), 0);
    end
    repeat (2) @(negedge clk);
    do @(negedge clk); while (pcyc % 10 != 0);
    ncr = 1'b1;
    r = pcyc + 1;
    wait_valid(0, 200, a0);
    check("post_rst_valid_cycle", 0, a0, r + 101);
    check("post_rst_freq", 0, 32'(freq_obs[0]), 32'h000010);
    wait_valid(1, 200, b);
    check("post_rst_valid_cycle", 1, b, r + 201);
    check("post_rst_freq", 1, 32'(freq_obs[1]), 32'h000100);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no end of run want finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frequency_meter.md
FREQUENCY_METER -- requirements
Module: frequency_meter

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50000000, meaning the gate window length in CP cycles (1 s at 50 MHz).
REQ-002 The block SHALL have parameter DIGITS, default 6, meaning the number of 8421 BCD result digits.
REQ-003 The block SHALL have port CP  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port nCR  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port EN  input  1  measurement enable, high active.
REQ-006 The block SHALL have port SIG_IN  input  1  signal under measurement, asynchronous to CP.
REQ-007 The block SHALL have port FREQ_BCD  output  4*DIGITS  last latched edge count, BCD, digit 0 in bits [3:0].
REQ-008 The block SHALL have port VALID  output  1  one-cycle pulse when FREQ_BCD updates.
REQ-009 The block SHALL have port OVF  output  1  latched result saturated.
REQ-010 The block SHALL have port BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-011 SIG_IN SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge SHALL be detected when sync=1 and history=0.
REQ-012 Latency from a SIG_IN rising edge to the internal count increment SHALL be 3 CP cycles.
REQ-013 The maximum measurable rate SHALL be CP/2; faster inputs alias, with no error flag.
REQ-014 The FSM SHALL have states IDLE, MEASURE, and LATCH.
REQ-015 IDLE: gate counter=0 and edge count=0; EN=1 SHALL move the FSM to MEASURE on the next cycle.
REQ-016 MEASURE SHALL increment the gate counter 0..GATE_CYCLES-1 and count each detected edge.
REQ-017 In MEASURE, the cycle with gate counter=GATE_CYCLES-1 SHALL still count its edge, then the FSM SHALL go to LATCH.
REQ-018 LATCH SHALL last exactly one cycle and perform all of the following:
- FREQ_BCD<=edge count;
- OVF<=overflow flag;
- VALID=1;
- edge count, overflow flag and gate counter cleared;
- next state MEASURE if EN=1, else IDLE.
REQ-019 An edge detected during the LATCH cycle SHALL be discarded; dead time between windows SHALL be exactly 1 cycle, giving a VALID period of GATE_CYCLES+1.
REQ-020 EN=0 during MEASURE SHALL abort to IDLE next cycle, discard the partial count, and assert no VALID; FREQ_BCD and OVF SHALL hold.
REQ-021 The edge count SHALL be a DIGITS-digit BCD counter, each digit 0..9; 9+1 SHALL give 0 with carry into the next digit, rippling within the same cycle.
REQ-022 At all-9s, a further edge SHALL leave the count at all-9s and set the overflow flag, which stays set until LATCH.
REQ-023 Outside the LATCH cycle, FREQ_BCD and OVF SHALL hold; VALID SHALL be 0.

Reset
REQ-024 nCR=0 SHALL immediately force:
- state IDLE;
- FREQ_BCD=0, VALID=0, OVF=0, BUSY=0;
- gate counter and edge count=0;
- synchronizer and history flops=0.
REQ-025 Reset mid-MEASURE SHALL discard the window.
REQ-026 After nCR rises with EN=1, the first VALID SHALL occur GATE_CYCLES+1 cycles after MEASURE entry.

Verification
REQ-027 GATE_CYCLES=100, DIGITS=6, SIG_IN period 10 CP, EN=1 -> every VALID shows FREQ_BCD=0x000010, OVF=0, VALID spacing 101 cycles.
REQ-028 GATE_CYCLES=200, SIG_IN period 2 CP -> FREQ_BCD=0x000100, exercising the 99->100 two-digit ripple carry.
REQ-029 DIGITS=2, GATE_CYCLES=300, SIG_IN period 2 -> FREQ_BCD=0x99, OVF=1; next window with SIG_IN=0 -> FREQ_BCD=0x00, OVF=0.
REQ-030 SIG_IN held constant 1 -> FREQ_BCD=0 at every VALID.
REQ-031 EN dropped at gate count 50 -> no VALID, BUSY=0 next cycle, FREQ_BCD unchanged; EN re-raised -> full fresh window.
REQ-032 nCR pulsed low mid-MEASURE -> all outputs 0 asynchronously; the first VALID after release follows REQ-026 timing with a correct count.
